// File: rtl/fire7_pkg.sv
// Shared fire7 constants and the squeeze-OFM writer state encoding.
package fire7_pkg;
  localparam int F7_DSP_NO = 64;
  localparam int F7_WIDTH  = 16;
  localparam int F7_WOUT   = 16;
  localparam int F7_PLANE  = F7_WOUT * F7_WOUT;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} f7_state_e;
endpackage

// File: rtl/fire7_squeeze_ofm_writer.sv
// Captures one squeeze pixel bank per strobe and serialises it into the fire7
// feature-map RAM in channel-major order, pulsing ram_feedback after the last bank.
module fire7_squeeze_ofm_writer
  import fire7_pkg::*;
#(
  parameter int DSP_NO = F7_DSP_NO,
  parameter int WIDTH  = F7_WIDTH,
  parameter int WOUT   = F7_WOUT,
  parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rearm,
  input  logic              fire7_squeeze_sample,
  input  logic [WIDTH-1:0]  ofm_in [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_feedback,
  output logic              busy,
  output logic              overrun
);
  localparam int PLANE = WOUT * WOUT;
  localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PIX_W = (PLANE > 1) ? $clog2(PLANE) : 1;
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(DSP_NO - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(PLANE - 1);
  localparam logic [ADDR_W-1:0] PLANE_STEP = ADDR_W'(PLANE);

  f7_state_e         state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              fb_q, fb_d;
  logic              ovr_q, ovr_d;
  logic              capture;
  logic [WIDTH-1:0]  shadow_q [0:DSP_NO-1];

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    acc_d   = acc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fb_d    = 1'b0;
    ovr_d   = ovr_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire7_squeeze_sample) begin
          capture = 1'b1;
          ch_d    = '0;
          acc_d   = ADDR_W'(pix_q);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Address walks by one plane per channel from the pixel offset.
        we_d    = 1'b1;
        wdata_d = shadow_q[ch_q];
        addr_d  = acc_q;
        acc_d   = acc_q + PLANE_STEP;
        if (fire7_squeeze_sample) ovr_d = 1'b1;
        if (ch_q == CH_LAST) begin
          ch_d    = '0;
          pix_d   = pix_q + 1'b1;
          state_d = (pix_q == PIX_LAST) ? DONE : IDLE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      DONE: begin
        // The final write is still on the outputs during the first DONE cycle.
        fb_d = we_q;
        if (rearm) begin
          state_d = IDLE;
          pix_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pix_q   <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fb_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      acc_q   <= acc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      fb_q    <= fb_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) shadow_q <= ofm_in;
  end

  assign ram_we       = we_q;
  assign busy         = we_q;
  assign ram_addr     = addr_q;
  assign ram_wdata    = wdata_q;
  assign ram_feedback = fb_q;
  assign overrun      = ovr_q;
endmodule

// File: tb/tb_fire7_squeeze_ofm_writer.sv
// Randomised bench: a strobe-level model predicts every RAM write, feedback and overrun.
module tb_fire7_squeeze_ofm_writer;
  import fire7_pkg::*;

  localparam int BIG = 32'h7fff_ffff;

  typedef struct {
    int          when_n;
    logic [13:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rearm = 1'b0;
  logic        fire7_squeeze_sample = 1'b0;
  logic [15:0] ofm_in    [0:F7_DSP_NO-1];
  logic [15:0] bank_data [0:F7_DSP_NO-1];
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_feedback;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wr_count = 0;
  int fb_count = 0;

  // Reference model state
  wr_t exp_q[$];
  int  t_prev = -1000;
  int  m_pix = 0;
  bit  m_done = 1'b0;
  int  ovr_edge = BIG;
  int  fb_edge = -1;

  fire7_squeeze_ofm_writer dut (
    .clk                  (clk),
    .rst                  (rst),
    .rearm                (rearm),
    .fire7_squeeze_sample (fire7_squeeze_sample),
    .ofm_in               (ofm_in),
    .ram_we               (ram_we),
    .ram_addr             (ram_addr),
    .ram_wdata            (ram_wdata),
    .ram_feedback         (ram_feedback),
    .busy                 (busy),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, cyc = rising edges so far.
  always @(negedge clk) begin
    bit  exp_we;
    wr_t w;
    while (exp_q.size() > 0 && exp_q[0].when_n < cyc) void'(exp_q.pop_front());
    exp_we = (exp_q.size() > 0) && (exp_q[0].when_n == cyc);
    check("ram_we", 32'(ram_we), 32'(exp_we));
    check("busy", 32'(busy), 32'(exp_we));
    if (ram_we === 1'b1) wr_count++;
    if (ram_feedback === 1'b1) fb_count++;
    if (exp_we) begin
      w = exp_q.pop_front();
      check("ram_addr", 32'(ram_addr), 32'(w.addr));
      check("ram_wdata", 32'(ram_wdata), 32'(w.data));
    end
    check("ram_feedback", 32'(ram_feedback), 32'(cyc == fb_edge));
    check("overrun", 32'(overrun), 32'(cyc >= ovr_edge));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    t_prev   = -1000;
    m_pix    = 0;
    m_done   = 1'b0;
    ovr_edge = BIG;
    fb_edge  = -1;
  endtask

  // Called just after a rising edge; the strobe is seen at the next edge.
  task automatic send_sample(input string tn);
    int    e;
    string what;
    wr_t   w;
    ofm_in = bank_data;
    fire7_squeeze_sample = 1'b1;
    e = cyc + 1;
    if (e <= t_prev + F7_DSP_NO) begin
      what = "dropped_overrun";
      if (ovr_edge > e) ovr_edge = e;
    end else if (m_done) begin
      what = "ignored_done";
    end else begin
      what = "accepted";
      t_prev = e;
      for (int c = 0; c < F7_DSP_NO; c++) begin
        w.when_n = e + 1 + c;
        w.addr   = 14'(c * F7_PLANE + m_pix);
        w.data   = bank_data[c];
        exp_q.push_back(w);
      end
      m_pix++;
      if (m_pix == F7_PLANE) begin
        m_done  = 1'b1;
        m_pix   = 0;
        fb_edge = e + F7_DSP_NO + 1;
      end
    end
    $display("[%s] sample @edge %0d %s (next pix %0d)", tn, e, what, m_pix);
    tick(1);
    fire7_squeeze_sample = 1'b0;
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    if (m_done && (cyc + 1 > t_prev + F7_DSP_NO)) begin
      m_done = 1'b0;
      m_pix  = 0;
    end
    tick(1);
    rearm = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks the asynchronous clear.
  task automatic do_reset(input string tn);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    check({tn, "_we"}, 32'(ram_we), 32'd0);
    check({tn, "_addr"}, 32'(ram_addr), 32'd0);
    check({tn, "_wdata"}, 32'(ram_wdata), 32'd0);
    check({tn, "_fb"}, 32'(ram_feedback), 32'd0);
    check({tn, "_busy"}, 32'(busy), 32'd0);
    check({tn, "_ovr"}, 32'(overrun), 32'd0);
    $display("[%s] reset asserted @cyc %0d", tn, cyc);
    tick(2);
    #1 rst = 1'b1;
    tick(1);
  endtask

  task automatic rand_bank();
    for (int c = 0; c < F7_DSP_NO; c++) bank_data[c] = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int c = 0; c < F7_DSP_NO; c++) ofm_in[c] = '0;
    tick(1);
    do_reset("por");

    // 1: single bank with a known pattern
    for (int c = 0; c < F7_DSP_NO; c++) bank_data[c] = 16'(16'h0100 + c);
    wr_count = 0;
    send_sample("t1");
    tick(70);
    check("t1_writes", 32'(wr_count), 32'd64);

    // 6: strobe in the last DRAIN cycle, then one in IDLE right after
    rand_bank();
    wr_count = 0;
    send_sample("t6");
    tick(F7_DSP_NO - 1);
    rand_bank();
    send_sample("t6_last");
    rand_bank();
    send_sample("t6_next");
    tick(70);
    check("t6_writes", 32'(wr_count), 32'd128);
    check("t6_ovr", 32'(overrun), 32'd1);

    // 3: strobe 10 cycles after an accepted one
    do_reset("t3_rst");
    rand_bank();
    wr_count = 0;
    send_sample("t3");
    tick(9);
    rand_bank();
    send_sample("t3_early");
    tick(70);
    check("t3_writes", 32'(wr_count), 32'd64);
    check("t3_ovr", 32'(overrun), 32'd1);

    // 5: reset at channel 30 of bank 5
    do_reset("t5_rst");
    for (int k = 0; k < 6; k++) begin
      rand_bank();
      send_sample("t5");
      if (k < 5) tick(70);
    end
    tick(31);
    do_reset("t5_mid");
    rand_bank();
    wr_count = 0;
    send_sample("t5_after");
    tick(70);
    check("t5_writes", 32'(wr_count), 32'd64);

    // 2: full frame with randomised legal spacing
    do_reset("t2_rst");
    wr_count = 0;
    fb_count = 0;
    for (int k = 0; k < F7_PLANE; k++) begin
      rand_bank();
      send_sample("t2");
      if (k == 100) pulse_rearm();
      tick($urandom_range(64, 79));
    end
    tick(10);
    check("t2_writes", 32'(wr_count), 32'(F7_DSP_NO * F7_PLANE));
    check("t2_fb_pulses", 32'(fb_count), 32'd1);

    // 4: trailing strobes in DONE, then rearm and restart
    base = wr_count;
    for (int k = 0; k < 3; k++) begin
      rand_bank();
      send_sample("t4_done");
      tick(5);
    end
    tick(70);
    check("t4_no_writes", 32'(wr_count - base), 32'd0);
    check("t4_ovr", 32'(overrun), 32'd0);
    pulse_rearm();
    rand_bank();
    send_sample("t4_rearm");
    tick(70);
    check("t4_writes", 32'(wr_count - base), 32'd64);
    check("t4_fb_pulses", 32'(fb_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
